key_load_ctrl: RTL and testbench
================================

Name: key_load_ctrl

Overview:
- Sequencer that serially loads the unlock key for a logic-locked FSM (keyinput bus) and holds that FSM in reset until a parity-checked key is stable.
- Sits between the key-provisioning interface (tester/scan or on-chip key store) and the locked controller. Drives the controller's keyinput bus and its active-high rst.
- Supports reload, error lockout and zeroisation.

Parameters:
- KEY_W, 8, number of key bits driven to the locked FSM (1..64).
- SETTLE_CYC, 4, cycles the key is held stable with the FSM still in reset before release (0..255; 0 skips SETTLE).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse; begin a (re)load of the key.
- key_bit  in  1  serial key data, LSB first, then one parity bit.
- key_bit_valid  in  1  key_bit qualifier.
- key_bit_ready  out  1  block accepts key_bit this cycle.
- zeroize  in  1  clear key and lock the FSM; highest priority.
- key_out  out  KEY_W  key to the locked FSM keyinput bus.
- fsm_rst  out  1  active-high reset to the locked FSM.
- busy  out  1  load or settle in progress.
- loaded  out  1  valid key applied, FSM released.
- err  out  1  last load failed its parity check.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, key_out=0, shadow=0, bit_cnt=0, settle_cnt=0, fsm_rst=1, key_bit_ready=0, busy=0, loaded=0, err=0. All outputs are registered.
- States: IDLE, SHIFT, CHECK, SETTLE, RUN, ERROR.
- IDLE: ready=0, fsm_rst=1. load_start -> SHIFT.
- On any entry to SHIFT: shadow=0, bit_cnt=0, key_out=0, fsm_rst=1, busy=1, loaded=0, err=0.
- SHIFT:
  - ready=1.
  - Handshake: a bit is accepted on an edge where valid && ready.
  - Data bits 0..KEY_W-1: shadow <= {key_bit, shadow[KEY_W-1:1]}, bit_cnt++, running parity ^= key_bit.
  - Bit KEY_W is the parity bit. Even parity is required: XOR of all KEY_W+1 bits must be 0. Accepting it moves the state to CHECK.
- CHECK: one cycle, ready=0.
  - Parity good: key_out<=shadow; go to SETTLE with settle_cnt=SETTLE_CYC, or straight to RUN if SETTLE_CYC=0.
  - Parity bad: shadow<=0, err<=1, go to ERROR.
- SETTLE: fsm_rst=1, key_out stable. settle_cnt decrements each cycle; the block spends exactly SETTLE_CYC cycles here, then moves to RUN.
- RUN: fsm_rst=0, loaded=1, busy=0. key_out holds. load_start -> SHIFT, which reasserts fsm_rst and clears key_out on the next edge.
- ERROR: fsm_rst=1, key_out=0, err=1, ready=0. Only load_start (-> SHIFT, err cleared) or zeroize leaves this state.
- Latency: the parity bit is accepted at edge E0. key_out is updated at E0+1. fsm_rst falls at edge E0+1+SETTLE_CYC (E0+5 at default), and loaded rises on the same edge.
- Boundary and priority rules:
  - zeroize wins in every state: next edge gives IDLE, key_out=0, shadow=0, fsm_rst=1, loaded=0, err=0, busy=0.
  - load_start in SHIFT, CHECK or SETTLE restarts the load; a bit offered in the same cycle is discarded.
  - load_start together with zeroize: zeroize wins.
  - key_bit_valid outside SHIFT is ignored (ready=0).
  - Gaps in valid during SHIFT are permitted with no timeout; bit_cnt holds.
  - rst asserted mid-load or in RUN immediately forces the reset values above, including fsm_rst=1.
- Widths: bit_cnt is $clog2(KEY_W+1) bits; settle_cnt is 8 bits.

Decomposition:
- Shared package lock_ctrl_pkg holds:
  - the state enum;
  - the KEY_W default;
  - the parity-polarity constant (EVEN);
  - the reset values of key_out and fsm_rst.
- One sub-module, key_shift_par: KEY_W shift register plus running parity and bit counter, with clear/shift/done ports.
- key_load_ctrl holds the FSM and settle counter, and instantiates key_shift_par.

Test Plan:
- Good load, KEY_W=8, SETTLE_CYC=4: load_start, then bits 1,0,1,0,0,1,0,1 with parity 0 -> key_out=0xA5 one edge after the parity bit; fsm_rst falls 5 edges after parity acceptance; loaded=1; busy=0.
- Bad parity: same data with parity bit 1 -> ERROR, err=1, key_out=0, fsm_rst stays 1. A subsequent load_start clears err and re-enters SHIFT with ready=1.
- Restart mid-shift: load_start after 3 accepted bits, then a full 0x3C frame (parity 0) -> key_out=0x3C; the first 3 bits have no effect.
- Zeroize in RUN with key 0xA5 -> next edge key_out=0, fsm_rst=1, loaded=0, state IDLE. Zeroize asserted together with load_start -> IDLE, not SHIFT.
- Reload from RUN: load_start -> fsm_rst=1 and key_out=0 on the next edge; after a new frame 0xFF (parity 0), key_out=0xFF and the FSM is released after SETTLE_CYC.
- Async reset mid-SETTLE: drop rst between edges -> fsm_rst=1, key_out=0, busy=0 immediately, without waiting for a clock edge. With SETTLE_CYC=0, fsm_rst falls 1 edge after parity acceptance.

Source files
------------

// File: rtl/lock_ctrl_pkg.sv
// lock_ctrl_pkg: shared types and constants for the key load sequencer
package lock_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_SETTLE, S_RUN, S_ERROR} state_t;
    localparam int KEY_W_DEF = 8;
    localparam logic EVEN = 1'b0;
    localparam logic KEY_RST_BIT = 1'b0;
    localparam logic FSM_RST_VAL = 1'b1;
endpackage

// File: rtl/key_shift_par.sv
// key_shift_par: LSB-first key shift register with running parity and bit counter
module key_shift_par import lock_ctrl_pkg::*; #(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             parity_ok,
    output logic             done
);
    localparam int CW = $clog2(KEY_W + 1);
    logic [CW-1:0] bit_cnt;
    logic          par;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow  <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else if (clear) begin
            shadow  <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else if (shift) begin
            par <= par ^ bit_in;
            // once full, the incoming bit is the parity bit and only folds into par
            if (!done) begin
                shadow  <= KEY_W'({bit_in, shadow} >> 1);
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
    assign done      = bit_cnt == CW'(KEY_W);
    assign parity_ok = par == EVEN;
endmodule

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: loads a parity-checked unlock key and holds the locked FSM in reset until it settles
module key_load_ctrl import lock_ctrl_pkg::*; #(
    parameter int KEY_W      = KEY_W_DEF,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_bit_valid,
    output logic             key_bit_ready,
    input  logic             zeroize,
    output logic [KEY_W-1:0] key_out,
    output logic             fsm_rst,
    output logic             busy,
    output logic             loaded,
    output logic             err
);
    state_t           state, nxt;
    logic [7:0]       settle_cnt, cnt_nxt;
    logic [KEY_W-1:0] key_nxt, shadow;
    logic             fsm_rst_nxt, rdy_nxt, busy_nxt, loaded_nxt, err_nxt;
    logic             clear, shift, full, parity_ok, release_now;
    assign shift = key_bit_ready && key_bit_valid && !load_start && !zeroize;
    key_shift_par #(.KEY_W(KEY_W)) u_shift (
        .clk(clk), .rst(rst), .clear(clear), .shift(shift), .bit_in(key_bit),
        .shadow(shadow), .parity_ok(parity_ok), .done(full)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            key_out       <= {KEY_W{KEY_RST_BIT}};
            fsm_rst       <= FSM_RST_VAL;
            key_bit_ready <= 1'b0;
            busy          <= 1'b0;
            loaded        <= 1'b0;
            err           <= 1'b0;
            settle_cnt    <= '0;
        end else begin
            state         <= nxt;
            key_out       <= key_nxt;
            fsm_rst       <= fsm_rst_nxt;
            key_bit_ready <= rdy_nxt;
            busy          <= busy_nxt;
            loaded        <= loaded_nxt;
            err           <= err_nxt;
            settle_cnt    <= cnt_nxt;
        end
    end
    assign release_now = (state == S_CHECK && parity_ok && SETTLE_CYC == 0) ||
                         (state == S_SETTLE && settle_cnt == 8'd1);
    always_comb begin
        nxt         = state;
        key_nxt     = key_out;
        fsm_rst_nxt = fsm_rst;
        rdy_nxt     = key_bit_ready;
        busy_nxt    = busy;
        loaded_nxt  = loaded;
        err_nxt     = err;
        cnt_nxt     = settle_cnt;
        clear       = 1'b0;
        if (zeroize || load_start) begin
            nxt         = zeroize ? S_IDLE : S_SHIFT;
            key_nxt     = {KEY_W{KEY_RST_BIT}};
            fsm_rst_nxt = FSM_RST_VAL;
            rdy_nxt     = !zeroize;
            busy_nxt    = !zeroize;
            loaded_nxt  = 1'b0;
            err_nxt     = 1'b0;
            cnt_nxt     = '0;
            clear       = 1'b1;
        end else begin
            case (state)
                S_SHIFT: begin
                    if (shift && full) begin
                        nxt     = S_CHECK;
                        rdy_nxt = 1'b0;
                    end
                end
                S_CHECK: begin
                    if (parity_ok) begin
                        key_nxt = shadow;
                        cnt_nxt = 8'(SETTLE_CYC);
                        nxt     = S_SETTLE;
                    end else begin
                        nxt      = S_ERROR;
                        err_nxt  = 1'b1;
                        busy_nxt = 1'b0;
                        clear    = 1'b1;
                    end
                end
                S_SETTLE: cnt_nxt = settle_cnt - 1'b1;
                default: ;
            endcase
            if (release_now) begin
                nxt         = S_RUN;
                fsm_rst_nxt = 1'b0;
                loaded_nxt  = 1'b1;
                busy_nxt    = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_key_load_ctrl.sv
// tb_key_load_ctrl: scoreboard bench for key_load_ctrl (SETTLE_CYC=4 and SETTLE_CYC=0 instances)
module tb_key_load_ctrl;
    logic clk = 1'b0, rst = 1'b0, load_start = 1'b0, key_bit = 1'b0, key_bit_valid = 1'b0, zeroize = 1'b0;
    logic ready, ready0, fsm_rst, fsm_rst0, busy, busy0, loaded, loaded0, err, err0;
    logic [7:0] key_out, key_out0;
    int checks = 0, errors = 0;
    typedef struct packed { logic [7:0] key; logic [7:0] lat; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    key_load_ctrl #(.KEY_W(8), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .key_bit(key_bit), .key_bit_valid(key_bit_valid),
        .key_bit_ready(ready), .zeroize(zeroize), .key_out(key_out), .fsm_rst(fsm_rst),
        .busy(busy), .loaded(loaded), .err(err)
    );
    key_load_ctrl #(.KEY_W(8), .SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .load_start(load_start), .key_bit(key_bit), .key_bit_valid(key_bit_valid),
        .key_bit_ready(ready0), .zeroize(zeroize), .key_out(key_out0), .fsm_rst(fsm_rst0),
        .busy(busy0), .loaded(loaded0), .err(err0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic z);
        load_start = 1'b1;
        zeroize = z;
        tick;
        load_start = 1'b0;
        zeroize = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        repeat ($urandom_range(0, 2)) tick;
        key_bit = b;
        key_bit_valid = 1'b1;
        for (int i = 0; i < 20 && !ready; i++) tick;
        chk("bit_ready", ready, 1);
        tick;
        key_bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
    endtask

    task automatic finish_load;
        exp_t e;
        int n = 0;
        while (fsm_rst && n < 30) begin
            tick;
            n++;
            if (n == 1) begin
                chk("key_e1", key_out, sb[0].key);
                chk("s0_fsm_rst", fsm_rst0, 0);
                chk("s0_loaded", loaded0, 1);
            end
        end
        e = sb.pop_front();
        chk("key_run", key_out, e.key);
        chk("release_lat", n, e.lat);
        chk("loaded", loaded, 1);
        chk("busy_run", busy, 0);
    endtask

    initial begin
        repeat (2) tick;
        chk("rst_key", key_out, 0);
        chk("rst_fsm_rst", fsm_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        tick;
        // good load
        pulse_start(1'b0);
        chk("shift_ready", ready, 1);
        chk("shift_busy", busy, 1);
        chk("shift_fsm_rst", fsm_rst, 1);
        sb.push_back({8'hA5, 8'd5});
        send_frame(8'hA5, 1'b0);
        finish_load();
        // reload from RUN then bad parity
        pulse_start(1'b0);
        chk("reload_fsm_rst", fsm_rst, 1);
        chk("reload_key", key_out, 0);
        chk("reload_loaded", loaded, 0);
        send_frame(8'hA5, 1'b1);
        tick;
        chk("bad_err", err, 1);
        chk("bad_err0", err0, 1);
        chk("bad_key", key_out, 0);
        chk("bad_fsm_rst", fsm_rst, 1);
        chk("bad_busy", busy, 0);
        key_bit = 1'b1;
        key_bit_valid = 1'b1;
        repeat (3) tick;
        chk("err_hold", err, 1);
        chk("err_ready", ready, 0);
        chk("err_fsm_rst", fsm_rst, 1);
        key_bit_valid = 1'b0;
        pulse_start(1'b0);
        chk("err_clr", err, 0);
        chk("restart_ready", ready, 1);
        // restart mid-shift; the bit offered with load_start is dropped
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        key_bit = 1'b1;
        key_bit_valid = 1'b1;
        pulse_start(1'b0);
        key_bit_valid = 1'b0;
        chk("restart_ready0", ready0, 1);
        sb.push_back({8'h3C, 8'd5});
        send_frame(8'h3C, 1'b0);
        finish_load();
        // reload 0xFF from RUN
        pulse_start(1'b0);
        chk("reload2_fsm_rst", fsm_rst, 1);
        chk("reload2_key", key_out, 0);
        sb.push_back({8'hFF, 8'd5});
        send_frame(8'hFF, 1'b0);
        finish_load();
        // zeroize in RUN with 0xA5
        pulse_start(1'b0);
        sb.push_back({8'hA5, 8'd5});
        send_frame(8'hA5, 1'b0);
        finish_load();
        zeroize = 1'b1;
        tick;
        zeroize = 1'b0;
        chk("zero_key", key_out, 0);
        chk("zero_fsm_rst", fsm_rst, 1);
        chk("zero_loaded", loaded, 0);
        chk("zero_busy", busy, 0);
        chk("zero_ready", ready, 0);
        pulse_start(1'b1);
        chk("zs_ready", ready, 0);
        chk("zs_busy", busy, 0);
        key_bit_valid = 1'b1;
        repeat (2) tick;
        chk("idle_ready", ready, 0);
        key_bit_valid = 1'b0;
        // async reset mid-SETTLE
        pulse_start(1'b0);
        send_frame(8'h0F, 1'b0);
        tick;
        chk("settle_key", key_out, 8'h0F);
        chk("settle_busy", busy, 1);
        tick;
        #2 rst = 1'b0;
        #1;
        chk("arst_fsm_rst", fsm_rst, 1);
        chk("arst_key", key_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fsm_rst0", fsm_rst0, 1);
        chk("arst_key0", key_out0, 0);
        chk("arst_busy0", busy0, 0);
        tick;
        rst = 1'b1;
        tick;
        chk("post_rst_ready", ready, 0);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
